// File: rtl/input_vc_buffer.sv
// Per-input, per-VC flit FIFO feeding the VC allocator. Holds link flits,
// presents the head flit combinationally, pops on allocator grant, returns one
// registered credit per freed slot and tracks wormhole packet occupancy.

`ifndef FLIT_SIZE
`define FLIT_SIZE 8
`endif
`ifndef FLIT_TAIL
`define FLIT_TAIL 8
`endif

module input_vc_buffer #(
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2,
    parameter int FLIT_W   = `FLIT_SIZE,
    parameter int TAIL_IDX = `FLIT_TAIL
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flit_valid_in,
    input  logic [1:FLIT_W] link_flit_in,
    input  logic            credit_for_input,
    output logic            is_new_flit,
    output logic [1:FLIT_W] flit_out,
    output logic            credit_out,
    output logic            pkt_active,
    output logic [0:PTR_W]  occupancy,
    output logic            overflow_err
);

    typedef enum logic {
        PKT_IDLE   = 1'b0,
        PKT_ACTIVE = 1'b1
    } pkt_state_e;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [1:FLIT_W]  mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             credit_q, credit_d;
    logic             ovf_q, ovf_d;
    pkt_state_e       state_q, state_d;

    logic             full;
    logic             push;
    logic             pop;
    logic [1:FLIT_W]  head_flit;
    logic             head_is_tail;

    // Handshake decode and head-of-queue view, all from registered state.
    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave it
        // unassigned; an unassigned path would infer a latch.
        full         = (occ_q == FULL_CNT);
        is_new_flit  = (occ_q != '0);
        pop          = credit_for_input & is_new_flit;
        // A full buffer still accepts a flit when the head leaves this cycle.
        push         = flit_valid_in & (~full | pop);
        head_flit    = mem_q[rd_ptr_q];
        head_is_tail = head_flit[TAIL_IDX];
        // Empty buffer shows zero rather than stale storage.
        flit_out     = is_new_flit ? head_flit : '0;
    end

    // Next-state for pointers, occupancy, credit, overflow and packet FSM.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        credit_d = pop;
        ovf_d    = ovf_q | (flit_valid_in & full & ~pop);
        state_d  = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        // Packet boundaries are only observed as flits leave the buffer.
        if (pop) begin
            case (state_q)
                PKT_IDLE:   state_d = head_is_tail ? PKT_IDLE : PKT_ACTIVE;
                PKT_ACTIVE: state_d = head_is_tail ? PKT_IDLE : PKT_ACTIVE;
                default:    state_d = PKT_IDLE;
            endcase
        end
    end

    // Control state register; reset wins over any traffic in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of every other flop, independent of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= PKT_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    // Flit storage write port; a flit arriving during reset is discarded.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; slots are only read once
        // occupancy says they hold a valid flit.
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= link_flit_in;
        end
    end

    assign credit_out   = credit_q;
    assign pkt_active   = (state_q == PKT_ACTIVE);
    assign occupancy    = occ_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed self-checking bench for input_vc_buffer (DEPTH=4, 8-bit flits,
// tail bit at index 8, i.e. the flit LSB).

module tb_input_vc_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flit_valid_in = 1'b0;
    logic [1:8] link_flit_in = '0;
    logic       credit_for_input = 1'b0;
    logic       is_new_flit;
    logic [1:8] flit_out;
    logic       credit_out;
    logic       pkt_active;
    logic [0:2] occupancy;
    logic       overflow_err;

    int checks = 0;
    int failures = 0;

    // Single-flit packets: all odd so the tail bit is set.
    logic [7:0] d_vals [5] = '{8'h11, 8'h23, 8'h35, 8'h47, 8'h59};
    // Six-flit packet: tail bit only on the last flit.
    logic [7:0] p_vals [6] = '{8'h80, 8'h82, 8'h84, 8'h86, 8'h88, 8'h8B};

    input_vc_buffer #(
        .DEPTH(4),
        .PTR_W(2),
        .FLIT_W(8),
        .TAIL_IDX(8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flit_valid_in    (flit_valid_in),
        .link_flit_in     (link_flit_in),
        .credit_for_input (credit_for_input),
        .is_new_flit      (is_new_flit),
        .flit_out         (flit_out),
        .credit_out       (credit_out),
        .pkt_active       (pkt_active),
        .occupancy        (occupancy),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held two cycles, then idle for ten.
        reset = 1'b1;
        tick();
        tick();
        check("rst_occ", 32'(occupancy), 0);
        check("rst_new", 32'(is_new_flit), 0);
        check("rst_credit", 32'(credit_out), 0);
        check("rst_pkt", 32'(pkt_active), 0);
        check("rst_ovf", 32'(overflow_err), 0);
        check("rst_flit", 32'(flit_out), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_new", 32'(is_new_flit), 0);
            check("idle_occ", 32'(occupancy), 0);
            check("idle_credit", 32'(credit_out), 0);
            check("idle_ovf", 32'(overflow_err), 0);
        end

        // Grant while empty is ignored: no credit, no occupancy change.
        credit_for_input = 1'b1;
        tick();
        credit_for_input = 1'b0;
        tick();
        check("empty_grant_credit", 32'(credit_out), 0);
        check("empty_grant_occ", 32'(occupancy), 0);

        // Single write then pop.
        flit_valid_in = 1'b1;
        link_flit_in  = 8'hA5;
        tick();
        flit_valid_in = 1'b0;
        check("single_new", 32'(is_new_flit), 1);
        check("single_flit", 32'(flit_out), 32'hA5);
        check("single_occ", 32'(occupancy), 1);
        check("single_credit_early", 32'(credit_out), 0);
        credit_for_input = 1'b1;
        tick();
        credit_for_input = 1'b0;
        check("single_occ_after", 32'(occupancy), 0);
        check("single_credit", 32'(credit_out), 1);
        check("single_pkt", 32'(pkt_active), 0);
        check("single_new_after", 32'(is_new_flit), 0);
        tick();
        check("single_credit_once", 32'(credit_out), 0);

        // Fill to DEPTH, then overflow with a fifth flit.
        for (int i = 0; i < 4; i++) begin
            flit_valid_in = 1'b1;
            link_flit_in  = d_vals[i];
            tick();
            check("fill_occ", 32'(occupancy), 32'(i + 1));
        end
        check("fill_ovf_clear", 32'(overflow_err), 0);
        link_flit_in = d_vals[4];
        tick();
        flit_valid_in = 1'b0;
        check("ovf_occ", 32'(occupancy), 4);
        check("ovf_set", 32'(overflow_err), 1);
        check("ovf_head", 32'(flit_out), 32'(d_vals[0]));
        tick();
        check("ovf_sticky", 32'(overflow_err), 1);

        // Drain four in order with back-to-back credits.
        credit_for_input = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_flit", 32'(flit_out), 32'(d_vals[i]));
            tick();
            check("drain_credit", 32'(credit_out), 1);
            check("drain_occ", 32'(occupancy), 32'(3 - i));
        end
        credit_for_input = 1'b0;
        tick();
        check("drain_credit_end", 32'(credit_out), 0);
        check("drain_ovf_sticky", 32'(overflow_err), 1);

        // Full with simultaneous push and pop: no overflow, D4 lands.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("clr_ovf", 32'(overflow_err), 0);
        for (int i = 0; i < 4; i++) begin
            flit_valid_in = 1'b1;
            link_flit_in  = d_vals[i];
            tick();
        end
        check("full_occ", 32'(occupancy), 4);
        link_flit_in     = d_vals[4];
        credit_for_input = 1'b1;
        tick();
        flit_valid_in = 1'b0;
        check("pp_occ", 32'(occupancy), 4);
        check("pp_ovf", 32'(overflow_err), 0);
        check("pp_credit", 32'(credit_out), 1);
        for (int i = 1; i < 5; i++) begin
            check("pp_drain_flit", 32'(flit_out), 32'(d_vals[i]));
            tick();
        end
        credit_for_input = 1'b0;
        check("pp_drain_occ", 32'(occupancy), 0);

        // Six-flit packet streamed with occupancy <= 1; pointers wrap.
        flit_valid_in = 1'b1;
        link_flit_in  = p_vals[0];
        tick();
        for (int i = 0; i < 6; i++) begin
            check("wrap_flit", 32'(flit_out), 32'(p_vals[i]));
            credit_for_input = 1'b1;
            flit_valid_in    = (i < 5);
            if (i < 5) link_flit_in = p_vals[i + 1];
            tick();
            check("wrap_credit", 32'(credit_out), 1);
            check("wrap_pkt", 32'(pkt_active), (i < 5) ? 32'd1 : 32'd0);
            check("wrap_occ", 32'(occupancy), (i < 5) ? 32'd1 : 32'd0);
        end
        credit_for_input = 1'b0;
        flit_valid_in    = 1'b0;
        tick();
        check("wrap_credit_end", 32'(credit_out), 0);

        // Reset mid-operation with occupancy 3 and a packet in flight.
        for (int i = 0; i < 4; i++) begin
            flit_valid_in = 1'b1;
            link_flit_in  = p_vals[i];
            tick();
        end
        flit_valid_in    = 1'b0;
        credit_for_input = 1'b1;
        tick();
        check("mid_occ", 32'(occupancy), 3);
        check("mid_pkt", 32'(pkt_active), 1);
        reset            = 1'b1;
        flit_valid_in    = 1'b1;
        link_flit_in     = 8'h3C;
        credit_for_input = 1'b1;
        tick();
        check("mid_rst_occ", 32'(occupancy), 0);
        check("mid_rst_pkt", 32'(pkt_active), 0);
        check("mid_rst_ovf", 32'(overflow_err), 0);
        check("mid_rst_new", 32'(is_new_flit), 0);
        check("mid_rst_credit", 32'(credit_out), 0);
        reset            = 1'b0;
        flit_valid_in    = 1'b0;
        credit_for_input = 1'b0;
        tick();
        check("post_rst_credit", 32'(credit_out), 0);
        check("post_rst_occ", 32'(occupancy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
